// File: rtl/vera_pkg.sv
// Shared constants, bus-sample type and increment decode for the VERA external-bus slave.
`timescale 1ns/1ps
package vera_pkg;

  localparam int PTR_W = 17;

  localparam logic [2:0] REG_ADDR_L = 3'd0;
  localparam logic [2:0] REG_ADDR_M = 3'd1;
  localparam logic [2:0] REG_ADDR_H = 3'd2;
  localparam logic [2:0] REG_DATA   = 3'd3;

  typedef struct packed {
    logic       cs_n;
    logic       rw_n;
    logic [2:0] a;
    logic [7:0] d;
  } bus_sample_t;

  localparam bus_sample_t BUS_IDLE = '{cs_n: 1'b1, rw_n: 1'b1, a: 3'd0, d: 8'h00};

  // INCR = 0 holds the pointer; INCR = n advances it by 2^(n-1).
  function automatic logic [PTR_W-1:0] incr_step(input logic [3:0] incr);
    logic [PTR_W-1:0] step;
    if (incr == 4'd0) begin
      step = {PTR_W{1'b0}};
    end else begin
      step = {{(PTR_W-1){1'b0}}, 1'b1} << (incr - 4'd1);
    end
    return step;
  endfunction

endpackage

// File: rtl/vera_vram.sv
// Single-port synchronous VRAM with 1-cycle read latency.
// Defining VRAM_INIT_PATTERN_EN preloads vram[a] = a[7:0] for simulation and bring-up.
`timescale 1ns/1ps
module vram #(
  parameter int VRAM_AW = 12
) (
  input  logic               clk,
  input  logic               we,
  input  logic [VRAM_AW-1:0] addr,
  input  logic [7:0]         wdata,
  output logic [7:0]         rdata
);

  localparam int DEPTH = 1 << VRAM_AW;

  logic [7:0] mem [DEPTH];

`ifdef VRAM_INIT_PATTERN_EN
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = i[7:0];
    end
  end
`else
`endif

  // Read and write share one address; the read returns the pre-write contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/vera_extbus_top.sv
// 6502-style external bus slave: PHI2 synchronizer, 4-register window and VRAM data port.
// Optional VRAM_INIT_PATTERN_EN preloads the VRAM pattern (see vram).
`timescale 1ns/1ps
module vera_extbus_top
  import vera_pkg::*;
#(
  parameter int VRAM_AW = 12
) (
  input  logic       clk25,
  input  logic       reset,
  input  logic       extbus_phi2,
  input  logic       extbus_cs_n,
  input  logic       extbus_rw_n,
  input  logic [2:0] extbus_a,
  inout  wire  [7:0] extbus_d
);

  logic             phi2_p1_r, phi2_p2_r, phi2_p3_r;
  bus_sample_t      bus_now_s, bus_p1_r, bus_p2_r, cap_r;
  logic [1:0]       fill_r;
  logic             armed_r;
  logic             commit_s;

  logic [PTR_W-1:0] ptr_r, ptr_nxt_s, step_s;
  logic [3:0]       incr_r, incr_nxt_s;
  logic [7:0]       latch_r, rd_val_s, vram_rdata_s;
  logic             vram_we_s, pf_req_s, pf_req_r, pf_load_r;

  assign bus_now_s = '{cs_n: extbus_cs_n, rw_n: extbus_rw_n, a: extbus_a, d: extbus_d};

  // Synchronizer and matched bus pipeline; arming waits for a real low phase after reset.
  always_ff @(posedge clk25) begin
    if (reset) begin
      phi2_p1_r <= 1'b0;
      phi2_p2_r <= 1'b0;
      phi2_p3_r <= 1'b0;
      bus_p1_r  <= BUS_IDLE;
      bus_p2_r  <= BUS_IDLE;
      cap_r     <= BUS_IDLE;
      fill_r    <= 2'b00;
      armed_r   <= 1'b0;
    end else begin
      phi2_p1_r <= extbus_phi2;
      phi2_p2_r <= phi2_p1_r;
      phi2_p3_r <= phi2_p2_r;
      bus_p1_r  <= bus_now_s;
      bus_p2_r  <= bus_p1_r;
      fill_r    <= {fill_r[0], 1'b1};
      if (fill_r[1] && !phi2_p2_r) begin
        armed_r <= 1'b1;
      end
      if (armed_r && phi2_p2_r) begin
        cap_r <= bus_p2_r;
      end
    end
  end

  assign commit_s = armed_r && phi2_p3_r && !phi2_p2_r && !cap_r.cs_n;
  assign step_s   = incr_step(incr_r);

  // Side effects of a committed bus cycle.
  always_comb begin
    ptr_nxt_s  = ptr_r;
    incr_nxt_s = incr_r;
    vram_we_s  = 1'b0;
    pf_req_s   = 1'b0;
    if (commit_s) begin
      if (!cap_r.rw_n) begin
        case (cap_r.a)
          REG_ADDR_L: begin
            ptr_nxt_s[7:0] = cap_r.d;
            pf_req_s       = 1'b1;
          end
          REG_ADDR_M: begin
            ptr_nxt_s[15:8] = cap_r.d;
            pf_req_s        = 1'b1;
          end
          REG_ADDR_H: begin
            ptr_nxt_s[PTR_W-1] = cap_r.d[0];
            incr_nxt_s         = cap_r.d[7:4];
            pf_req_s           = 1'b1;
          end
          REG_DATA: begin
            vram_we_s = !reset;
            ptr_nxt_s = ptr_r + step_s;
            pf_req_s  = 1'b1;
          end
          default: begin
            pf_req_s = 1'b0;
          end
        endcase
      end else if (cap_r.a == REG_DATA) begin
        ptr_nxt_s = ptr_r + step_s;
        pf_req_s  = 1'b1;
      end else begin
        pf_req_s = 1'b0;
      end
    end else begin
      pf_req_s = 1'b0;
    end
  end

  // Pointer, increment and prefetch latch; the latch loads one cycle after the RAM read.
  always_ff @(posedge clk25) begin
    if (reset) begin
      ptr_r     <= {PTR_W{1'b0}};
      incr_r    <= 4'd0;
      latch_r   <= 8'h00;
      pf_req_r  <= 1'b0;
      pf_load_r <= 1'b0;
    end else begin
      ptr_r     <= ptr_nxt_s;
      incr_r    <= incr_nxt_s;
      pf_req_r  <= pf_req_s;
      pf_load_r <= pf_req_r;
      if (pf_load_r) begin
        latch_r <= vram_rdata_s;
      end
    end
  end

  vram #(.VRAM_AW(VRAM_AW)) u_vram (
    .clk   (clk25),
    .we    (vram_we_s),
    .addr  (ptr_r[VRAM_AW-1:0]),
    .wdata (cap_r.d),
    .rdata (vram_rdata_s)
  );

  // Read-back mux, driven straight from the raw bus select lines.
  always_comb begin
    case (extbus_a)
      REG_ADDR_L: rd_val_s = ptr_r[7:0];
      REG_ADDR_M: rd_val_s = ptr_r[15:8];
      REG_ADDR_H: rd_val_s = {incr_r, 3'b000, ptr_r[PTR_W-1]};
      REG_DATA:   rd_val_s = latch_r;
      default:    rd_val_s = 8'h00;
    endcase
  end

  assign extbus_d = (!extbus_cs_n && extbus_rw_n) ? rd_val_s : 8'hzz;

endmodule

// File: tb/tb_vera_extbus_top.sv
// Directed plus randomized bench for vera_extbus_top against a byte-array reference model.
`timescale 1ns/1ps
module tb_vera_extbus_top;

  logic       clk25 = 1'b0;
  logic       reset;
  logic       phi2;
  logic       cs_n;
  logic       rw_n;
  logic [2:0] a;
  logic [7:0] d_drv;
  logic       d_oe;
  wire  [7:0] extbus_d;

  assign extbus_d = d_oe ? d_drv : 8'hzz;

  always #20 clk25 = ~clk25;

  vera_extbus_top #(.VRAM_AW(12)) dut (
    .clk25       (clk25),
    .reset       (reset),
    .extbus_phi2 (phi2),
    .extbus_cs_n (cs_n),
    .extbus_rw_n (rw_n),
    .extbus_a    (a),
    .extbus_d    (extbus_d)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0]  m_vram [4096];
  int unsigned m_ptr;
  int unsigned m_incr;
  logic [7:0]  m_latch;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_ptr   = 0;
    m_incr  = 0;
    m_latch = 8'h00;
  endtask

  task automatic m_advance();
    int unsigned step;
    step    = (m_incr == 0) ? 0 : (1 << (m_incr - 1));
    m_ptr   = (m_ptr + step) % 131072;
    m_latch = m_vram[m_ptr % 4096];
  endtask

  task automatic m_write(input logic [2:0] r, input logic [7:0] v);
    case (r)
      3'd0: m_ptr = (m_ptr & 32'h1FF00) | 32'(v);
      3'd1: m_ptr = (m_ptr & 32'h100FF) | (32'(v) << 8);
      3'd2: begin
        m_ptr  = (m_ptr & 32'h0FFFF) | (32'(v[0]) << 16);
        m_incr = 32'(v[7:4]);
      end
      3'd3: m_vram[m_ptr % 4096] = v;
      default: ;
    endcase
    if (r == 3'd3) m_advance();
    else if (r < 3'd3) m_latch = m_vram[m_ptr % 4096];
  endtask

  task automatic m_read(input logic [2:0] r, output logic [7:0] exp);
    case (r)
      3'd0: exp = 8'(m_ptr);
      3'd1: exp = 8'(m_ptr >> 8);
      3'd2: exp = 8'((m_incr << 4) | (m_ptr >> 16));
      3'd3: begin
        exp = m_latch;
        m_advance();
      end
      default: exp = 8'h00;
    endcase
  endtask

  // One slow 6502-style bus cycle; read data is sampled late in the PHI2 high phase.
  task automatic bus_cycle(input logic rw, input logic [2:0] ra, input logic [7:0] wd,
                           output logic [7:0] rd);
    phi2 = 1'b0; cs_n = 1'b0; rw_n = rw; a = ra; d_drv = wd; d_oe = !rw;
    #30; phi2 = 1'b1;
    #55; rd = extbus_d;
    #7;  phi2 = 1'b0;
    #20; cs_n = 1'b1; d_oe = 1'b0; rw_n = 1'b1;
    #140;
  endtask

  task automatic wr(input logic [2:0] ra, input logic [7:0] wd);
    logic [7:0] dummy;
    bus_cycle(1'b0, ra, wd, dummy);
    m_write(ra, wd);
  endtask

  task automatic rd_chk(input logic [2:0] ra, input logic [7:0] exp, input string tag);
    logic [7:0] obs, mexp;
    bus_cycle(1'b1, ra, 8'h00, obs);
    m_read(ra, mexp);
    check(tag, obs, exp);
  endtask

  task automatic rd_model(input logic [2:0] ra, input string tag);
    logic [7:0] obs, mexp;
    bus_cycle(1'b1, ra, 8'h00, obs);
    m_read(ra, mexp);
    check(tag, obs, mexp);
  endtask

  // With chip select off the DUT must leave the bus to whoever drives it.
  task automatic release_chk(input logic [7:0] v, input string tag);
    cs_n = 1'b1; rw_n = 1'b1; a = 3'd0; d_drv = v; d_oe = 1'b1;
    #10;
    check(tag, extbus_d, v);
    d_oe = 1'b0;
    #10;
  endtask

  initial begin
    logic [2:0] r;
    logic [7:0] v;

    reset = 1'b1; phi2 = 1'b0; cs_n = 1'b1; rw_n = 1'b1; a = 3'd0; d_drv = 8'h00; d_oe = 1'b0;
    for (int i = 0; i < 4096; i++) m_vram[i] = 8'h00;
    m_reset();
    repeat (4) @(negedge clk25);
    reset = 1'b0;
    repeat (3) @(negedge clk25);

    rd_chk(3'd0, 8'h00, "reset_addr_l");
    rd_chk(3'd1, 8'h00, "reset_addr_m");
    rd_chk(3'd2, 8'h00, "reset_addr_h");
    release_chk(8'h5A, "reset_bus_release_5a");
    release_chk(8'hA5, "reset_bus_release_a5");

    // Load vram[a] = a[7:0] through the data port so results do not depend on the build option.
    wr(3'd2, 8'h10); wr(3'd1, 8'h00); wr(3'd0, 8'h00);
    for (int i = 0; i < 4096; i++) wr(3'd3, 8'(i));

    wr(3'd0, 8'h12); wr(3'd1, 8'h00); wr(3'd2, 8'h00);
    for (int i = 0; i < 4; i++) rd_chk(3'd3, 8'h12, "fixed_data");
    rd_chk(3'd0, 8'h12, "fixed_addr_l");
    release_chk(8'hC3, "bus_release_nonzero_reg");

    wr(3'd2, 8'h10); wr(3'd1, 8'h00); wr(3'd0, 8'hFE);
    rd_chk(3'd3, 8'hFE, "incr_data0");
    rd_chk(3'd3, 8'hFF, "incr_data1");
    rd_chk(3'd3, 8'h00, "incr_data2");
    rd_chk(3'd0, 8'h01, "incr_addr_l");
    rd_chk(3'd1, 8'h01, "incr_addr_m");

    wr(3'd2, 8'h00); wr(3'd1, 8'h00); wr(3'd0, 8'h40);
    wr(3'd3, 8'hA5);
    rd_chk(3'd3, 8'hA5, "raw_same_addr");
    wr(3'd2, 8'h10); wr(3'd0, 8'h50);
    wr(3'd3, 8'h11); wr(3'd3, 8'h22);
    wr(3'd0, 8'h50);
    rd_chk(3'd3, 8'h11, "write_back0");
    rd_chk(3'd3, 8'h22, "write_back1");

    wr(3'd2, 8'h11); wr(3'd1, 8'hFF); wr(3'd0, 8'hFF);
    rd_chk(3'd3, 8'hFF, "wrap_data");
    rd_chk(3'd0, 8'h00, "wrap_addr_l");
    rd_chk(3'd1, 8'h00, "wrap_addr_m");
    rd_chk(3'd2, 8'h10, "wrap_addr_h");

    rd_chk(3'd5, 8'h00, "unmapped_read");
    wr(3'd6, 8'h99);
    rd_chk(3'd0, 8'h00, "unmapped_write_ignored");

    // Reset during the high phase of a DATA write: the write must be dropped.
    wr(3'd2, 8'h00); wr(3'd1, 8'h00); wr(3'd0, 8'h20);
    phi2 = 1'b0; cs_n = 1'b0; rw_n = 1'b0; a = 3'd3; d_drv = 8'h77; d_oe = 1'b1;
    #30; phi2 = 1'b1;
    @(negedge clk25); reset = 1'b1;
    repeat (2) @(negedge clk25); reset = 1'b0;
    #90; phi2 = 1'b0;
    #20; cs_n = 1'b1; d_oe = 1'b0; rw_n = 1'b1;
    #140;
    m_reset();
    for (int i = 0; i < 8; i++) rd_chk(3'(i), 8'h00, "after_abort_reg");
    wr(3'd0, 8'h20);
    rd_chk(3'd3, 8'h20, "abort_no_write");

    for (int k = 0; k < 300; k++) begin
      r = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) begin
        v = 8'($urandom);
        wr(r, v);
      end else begin
        rd_model(r, "random_read");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vera_extbus_top.md
# vera_extbus_top

Top-level of the video adapter's host-bus slave. It bridges the asynchronous 6502-style external bus (PHI2, CS_n, RW_n, A[2:0], D[7:0]) into the 25 MHz core clock domain. It exposes a 4-register window: a 17-bit VRAM address pointer and an auto-incrementing data port. The data port is backed by an on-chip VRAM.

## Interface
- VRAM_AW, 12: VRAM address width; depth is 2^VRAM_AW bytes, and the 17-bit pointer aliases modulo depth.
- clk25  in  1  core clock, 25 MHz; the only clock in the block.
- reset  in  1  synchronous, active-high reset.
- extbus_phi2  in  1  bus phase clock, asynchronous to clk25, nominally 8 MHz.
- extbus_cs_n  in  1  chip select, active low.
- extbus_rw_n  in  1  1 = read, 0 = write.
- extbus_a  in  3  register select.
- extbus_d  inout  8  data bus; tri-stated unless the block is driving it.

## Operation
- Register map:
  - 0 ADDR_L = ptr[7:0].
  - 1 ADDR_M = ptr[15:8].
  - 2 ADDR_H: bit0 = ptr[16]; bits[7:4] = INCR; bits[3:1] read 0.
  - 3 DATA.
  - 4–7 read 0x00; writes to them are ignored.
- Increment step: INCR=0 gives 0; INCR=n (n = 1..15) gives 1<<(n-1). The pointer wraps modulo 2^17.
- Read drive: extbus_d is driven combinationally whenever !cs_n && rw_n, with the selected register value. For DATA, the driven value comes from the prefetch latch. Otherwise extbus_d is Z.
- Bus cycle commit: a cycle is committed once, at the synchronized PHI2 falling edge, and only if the captured cs_n was 0.
  - Write to ADDR_L/M/H: update the register, then prefetch from the new pointer.
  - Write to DATA: write the captured byte to vram[ptr], then ptr += step, then prefetch.
  - Read of DATA: ptr += step, then prefetch.
  - Read of any other register: no side effect.
- Prefetch: a synchronous VRAM read. The latch is valid 2 clk25 cycles after commit.
- Read-after-write to the same address returns the new data.

## Timing
- Synchronizer: extbus_phi2 passes through a 2-FF synchronizer. cs_n, rw_n, a and d are registered through an identical 2-stage pipeline so their samples stay aligned with the phi2 samples.
- Capture: each clk25 cycle where the aligned phi2 sample is 1, the aligned bus sample overwrites the capture register.
- Commit pulse: fires on the first cycle where the aligned phi2 sample is 0 after a 1.
- Commit latency: 3 clk25 cycles after the real PHI2 fall, at most. The prefetch is complete within 5 cycles (200 ns), which is before the next PHI2 high phase.
- Reset values:
  - ptr = 0, INCR = 0, prefetch latch = 0x00.
  - Synchronizer, pipeline and capture registers are cleared to idle: phi2 = 0, cs_n = 1.
  - extbus_d is Z.
  - VRAM contents are not reset.
- Reset asserted mid-bus-cycle: the cycle is aborted and no VRAM write occurs. Bus cycles resume normally with the first full PHI2 high phase after reset is deasserted.
- Commit and reset in the same cycle: reset wins.

## Configuration
- VRAM_INIT_PATTERN_EN
  - Defined: VRAM is initialized so that vram[a] = a[7:0], for simulation and bring-up.
  - Undefined: VRAM has no initializer, so contents are undefined until written.

## Structure
- Package vera_pkg holds:
  - register offset constants (REG_ADDR_L/M/H, REG_DATA);
  - the 17-bit pointer width constant;
  - the increment-decode function (INCR → step).
- One sub-module, vram: single-port synchronous RAM with 1-cycle read latency, parameterized by VRAM_AW. It holds the VRAM_INIT_PATTERN_EN initializer.

## Test plan
All scenarios use VRAM_INIT_PATTERN_EN, PHI2 = 8 MHz, and clk25 = 25 MHz.
- Reset: release reset, read regs 0..2 → 0x00, 0x00, 0x00; with cs_n=1, extbus_d is Z.
- Fixed-pointer reads: write ADDR_L=0x12, ADDR_M=0x00, ADDR_H=0x00, then read DATA 4× → 0x12 each time; ADDR_L reads back 0x12.
- Auto-increment: write ADDR_H=0x10, ADDR_M=0x00, ADDR_L=0xFE, then read DATA 3× → 0xFE, 0xFF, 0x00; afterwards ADDR_L=0x01 and ADDR_M=0x01.
- Write path: with ptr=0x00040 and INCR=0, write DATA=0xA5, then read DATA → 0xA5. With INCR=1 (ADDR_H=0x10) and ptr=0x00050, write 0x11 and 0x22, reset ptr to 0x00050, read → 0x11, 0x22.
- Wrap: write ADDR_H=0x11 (ptr[16]=1, INCR=1), ADDR_M=0xFF, ADDR_L=0xFF. Read DATA → vram[0x1FFFF mod depth] = 0xFF; ADDR_L/M/H then read 0x00/0x00/0x10.
- Reset during write: assert reset while PHI2 is high in a DATA write of 0x77 at ptr 0x00020. vram[0x20] stays 0x20, and all registers read 0x00.
